// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester handshakes, response bus and shared-ALU connections for alu_share_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus the ALU.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CTRW  = 4
);
  logic             Req0, Req1;
  logic             Rdy0, Rdy1;
  logic [WIDTH-1:0] A0, B0, A1, B1;
  logic [CTRW-1:0]  Ctr0, Ctr1;
  logic             RspVld0, RspVld1;
  logic             Ack0, Ack1;
  logic [WIDTH-1:0] RspRes;
  logic             RspZero, RspOvf;
  logic [WIDTH-1:0] AluA, AluB;
  logic [CTRW-1:0]  AluCtr;
  logic [WIDTH-1:0] AluRes;
  logic             AluZero, AluOvf;
  logic             TrapClr;
  logic             Trap, TrapId;

  modport slave (
    input  Req0, Req1, A0, B0, A1, B1, Ctr0, Ctr1, Ack0, Ack1,
    input  AluRes, AluZero, AluOvf, TrapClr,
    output Rdy0, Rdy1, RspVld0, RspVld1, RspRes, RspZero, RspOvf,
    output AluA, AluB, AluCtr, Trap, TrapId
  );

  modport master (
    output Req0, Req1, A0, B0, A1, B1, Ctr0, Ctr1, Ack0, Ack1,
    output AluRes, AluZero, AluOvf, TrapClr,
    input  Rdy0, Rdy1, RspVld0, RspVld1, RspRes, RspZero, RspOvf,
    input  AluA, AluB, AluCtr, Trap, TrapId
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin front end time-sharing one 32-bit ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional sticky overflow trap with requester masking is enabled by defining ALU_ARB_OVTRAP_EN.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int CTRW    = 4,
  parameter int RR_INIT = 0
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CTRW-1:0]  ctr_q, ctr_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic             trap_q, trap_d, trap_id_q, trap_id_d;
  logic             mask0, mask1, req0_eff, req1_eff;
  logic             gnt0, gnt1, rdy0, rdy1;

`ifdef ALU_ARB_OVTRAP_EN
  assign mask0 = trap_q && !trap_id_q;
  assign mask1 = trap_q &&  trap_id_q;
`else
  logic unused_trap_clr;
  assign unused_trap_clr = bus.TrapClr;
  assign mask0 = 1'b0;
  assign mask1 = 1'b0;
`endif

  // On contention the requester that was not served last wins.
  assign req0_eff = bus.Req0 && !mask0;
  assign req1_eff = bus.Req1 && !mask1;
  assign gnt0     = req0_eff && (!req1_eff ||  last_q);
  assign gnt1     = req1_eff && (!req0_eff || !last_q);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    ctr_d     = ctr_q;
    res_d     = res_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    trap_d    = 1'b0;
    trap_id_d = 1'b0;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
`ifdef ALU_ARB_OVTRAP_EN
    trap_d    = trap_q;
    trap_id_d = trap_id_q;
    if (bus.TrapClr) begin
      trap_d    = 1'b0;
      trap_id_d = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        rdy0 = gnt0;
        rdy1 = gnt1;
        if (gnt0) begin
          a_d     = bus.A0;
          b_d     = bus.B0;
          ctr_d   = bus.Ctr0;
          owner_d = 1'b0;
          last_d  = 1'b0;
          state_d = EXEC;
        end else if (gnt1) begin
          a_d     = bus.A1;
          b_d     = bus.B1;
          ctr_d   = bus.Ctr1;
          owner_d = 1'b1;
          last_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.AluRes;
        zero_d  = bus.AluZero;
        ovf_d   = bus.AluOvf;
        state_d = RESP;
`ifdef ALU_ARB_OVTRAP_EN
        // A capture-edge overflow takes priority over a simultaneous TrapClr.
        if (bus.AluOvf) begin
          trap_d    = 1'b1;
          trap_id_d = owner_q;
        end
`endif
      end
      RESP: begin
        if ((!owner_q && bus.Ack0) || (owner_q && bus.Ack1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= (RR_INIT == 0);
      owner_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      ctr_q     <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      trap_q    <= 1'b0;
      trap_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctr_q     <= ctr_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      trap_q    <= trap_d;
      trap_id_q <= trap_id_d;
    end
  end

  assign bus.Rdy0    = rdy0;
  assign bus.Rdy1    = rdy1;
  assign bus.RspVld0 = (state_q == RESP) && !owner_q;
  assign bus.RspVld1 = (state_q == RESP) &&  owner_q;
  assign bus.RspRes  = res_q;
  assign bus.RspZero = zero_q;
  assign bus.RspOvf  = ovf_q;
  assign bus.AluA    = a_q;
  assign bus.AluB    = b_q;
  assign bus.AluCtr  = ctr_q;
  assign bus.Trap    = trap_q;
  assign bus.TrapId  = trap_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU_32 model on the shared ALU port.
// Trap expectations follow ALU_ARB_OVTRAP_EN so the same bench covers both builds.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

`ifdef ALU_ARB_OVTRAP_EN
  localparam bit TrapOn = 1'b1;
`else
  localparam bit TrapOn = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(32), .CTRW(4)) bus ();

  alu_share_arbiter #(.WIDTH(32), .CTRW(4), .RR_INIT(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ALU_32 behaviour: unknown control codes fall back to the add path.
  logic [31:0] alu_r;
  logic        alu_v;
  always_comb begin
    alu_r = bus.AluA + bus.AluB;
    alu_v = 1'b0;
    case (bus.AluCtr)
      4'b0000: alu_v = (bus.AluA[31] == bus.AluB[31]) && (alu_r[31] != bus.AluA[31]);
      4'b0010: begin
        alu_r = bus.AluA - bus.AluB;
        alu_v = (bus.AluA[31] != bus.AluB[31]) && (alu_r[31] != bus.AluA[31]);
      end
      4'b0011: alu_r = bus.AluA - bus.AluB;
      4'b0100: alu_r = bus.AluA & bus.AluB;
      4'b0101: alu_r = bus.AluA | bus.AluB;
      4'b0110: alu_r = bus.AluA ^ bus.AluB;
      4'b0111: alu_r = ~(bus.AluA | bus.AluB);
      4'b1010: alu_r = {31'b0, $signed(bus.AluA) < $signed(bus.AluB)};
      4'b1011: alu_r = {31'b0, bus.AluA < bus.AluB};
      default: ;
    endcase
    bus.AluRes  = alu_r;
    bus.AluOvf  = alu_v;
    bus.AluZero = (alu_r == 32'd0);
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctr;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic k0, input logic k1,
                               input logic clr);
    bus.Req0    = r0;
    bus.Req1    = r1;
    bus.Ack0    = k0;
    bus.Ack1    = k1;
    bus.TrapClr = clr;
  endtask

  // Raise a request, wait (bounded) for its grant, let it be accepted, then scramble the operands.
  // Returns with the DUT in EXEC, 1 time unit after the accept edge.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctr, output logic ok);
    int n = 0;
    @(negedge clk);
    if (id) begin
      bus.A1 = a; bus.B1 = b; bus.Ctr1 = ctr; bus.Req1 = 1'b1;
    end else begin
      bus.A0 = a; bus.B0 = b; bus.Ctr0 = ctr; bus.Req0 = 1'b1;
    end
    #1;
    while (!(id ? bus.Rdy1 : bus.Rdy0) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (n < 20);
    if (!ok) begin
      checkOutput("grant_timeout", 32'd0, 32'd1);
      if (id) bus.Req1 = 1'b0; else bus.Req0 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (id) begin
      bus.Req1 = 1'b0; bus.A1 = 32'hDEADBEEF; bus.B1 = 32'hCAFEF00D; bus.Ctr1 = 4'hF;
    end else begin
      bus.Req0 = 1'b0; bus.A0 = 32'hDEADBEEF; bus.B0 = 32'hCAFEF00D; bus.Ctr0 = 4'hF;
    end
  endtask

  task automatic runVector(input vec_t v);
    logic ok;
    issue(v.id, v.a, v.b, v.ctr, ok);
    if (!ok) return;
    checkOutput("exec_alua", bus.AluA, v.a);
    checkOutput("exec_alub", bus.AluB, v.b);
    checkOutput("exec_aluctr", {28'd0, bus.AluCtr}, {28'd0, v.ctr});
    checkOutput("exec_vld", {30'd0, bus.RspVld1, bus.RspVld0}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("resp_vld", {30'd0, bus.RspVld1, bus.RspVld0}, v.id ? 32'd2 : 32'd1);
    checkOutput("resp_res", bus.RspRes, v.res);
    checkOutput("resp_flags", {30'd0, bus.RspZero, bus.RspOvf}, {30'd0, v.zero, v.ovf});
    checkOutput("resp_rdy", {30'd0, bus.Rdy1, bus.Rdy0}, 32'd0);
    if (v.id) bus.Ack1 = 1'b1; else bus.Ack0 = 1'b1;
    @(posedge clk);
    #1;
    bus.Ack0 = 1'b0;
    bus.Ack1 = 1'b0;
    checkOutput("ack_idle_vld", {30'd0, bus.RspVld1, bus.RspVld0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        ok;
    logic [31:0] held;
    vec_t        tv;

    vecs[0] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 4'b0001, 32'h80000000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h00000005, 32'h00000005, 4'b0010, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 4'b1010, 32'h00000001, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 4'b1011, 32'h00000000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100, 32'h00F000F0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h12345678, 32'h0000FFFF, 4'b0101, 32'h1234FFFF, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h00000003, 32'h00000004, 4'b1111, 32'h00000007, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h80000000, 32'h00000001, 4'b0011, 32'h7FFFFFFF, 1'b0, 1'b0};

    // Reset state and Rdy following Req in IDLE.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0; bus.Ctr0 = '0; bus.Ctr1 = '0;
    #12;
    checkOutput("rst_alu_ab", bus.AluA | bus.AluB, 32'd0);
    checkOutput("rst_rsp", {bus.RspRes[29:0], bus.RspZero, bus.RspOvf}, 32'd0);
    checkOutput("rst_misc", {25'd0, bus.AluCtr, bus.RspVld0, bus.RspVld1, bus.Trap, bus.TrapId,
                             bus.Rdy0, bus.Rdy1}, 32'd0);
    bus.Req1 = 1'b1; #1;
    checkOutput("rst_rdy_single", {30'd0, bus.Rdy1, bus.Rdy0}, 32'd2);
    bus.Req0 = 1'b1; #1;
    checkOutput("rst_rdy_contested", {30'd0, bus.Rdy1, bus.Rdy0}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) runVector(vecs[i]);

    // Round-robin with both requests held from reset: grants 0,1,0,1.
    @(negedge clk);
    rst = 1'b1;
    bus.A0 = 32'd1; bus.B0 = 32'd2; bus.Ctr0 = 4'b0001;
    bus.A1 = 32'd5; bus.B1 = 32'd5; bus.Ctr1 = 4'b0010;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("rr_grant", {30'd0, bus.Rdy1, bus.Rdy0}, (k % 2) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rr_vld", {30'd0, bus.RspVld1, bus.RspVld0}, (k % 2) ? 32'd2 : 32'd1);
      checkOutput("rr_res", {bus.RspRes[30:0], bus.RspZero}, (k % 2) ? 32'd1 : 32'd6);
      if (k % 2) bus.Ack1 = 1'b1; else bus.Ack0 = 1'b1;
      @(posedge clk); #1;
      bus.Ack0 = 1'b0;
      bus.Ack1 = 1'b0;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure: response held 10 cycles, non-owner Ack ignored, no Rdy.
    issue(1'b0, 32'h0000000A, 32'h00000003, 4'b0010, ok);
    if (ok) begin
      @(posedge clk); #1;
      held = bus.RspRes;
      checkOutput("bp_res", held, 32'h00000007);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 10; c++) begin
        #1;
        checkOutput("bp_hold", {26'd0, bus.RspVld1, bus.RspVld0, bus.Rdy1, bus.Rdy0,
                                bus.RspZero, bus.RspOvf}, 32'b01_00_00);
        checkOutput("bp_res_stable", bus.RspRes, 32'h00000007);
        @(posedge clk);
      end
      #1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.Ack0 = 1'b0;
      checkOutput("bp_release", {30'd0, bus.RspVld1, bus.RspVld0}, 32'd0);
    end

    // Overflow trap on requester 1.
    tv = '{1'b1, 32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'h80000000, 1'b0, 1'b1};
    issue(tv.id, tv.a, tv.b, tv.ctr, ok);
    if (ok) begin
      @(posedge clk); #1;
      checkOutput("trap_rsp", {bus.RspRes[31:30], 28'd0, bus.RspZero, bus.RspOvf},
                  {2'b10, 28'd0, 1'b0, 1'b1});
      checkOutput("trap_set", {30'd0, bus.Trap, bus.TrapId}, TrapOn ? 32'd3 : 32'd0);
      bus.Ack1 = 1'b1;
      @(posedge clk); #1;
      bus.Ack1 = 1'b0;
      bus.Req1 = 1'b1; #1;
      checkOutput("trap_mask_rdy1", {31'd0, bus.Rdy1}, TrapOn ? 32'd0 : 32'd1);
      runVector(vecs[4]);
      bus.Req1 = 1'b0;
      checkOutput("trap_sticky", {30'd0, bus.Trap, bus.TrapId}, TrapOn ? 32'd3 : 32'd0);
      @(negedge clk);
      bus.TrapClr = 1'b1;
      @(posedge clk); #1;
      bus.TrapClr = 1'b0;
      checkOutput("trap_clear", {30'd0, bus.Trap, bus.TrapId}, 32'd0);
      bus.Req1 = 1'b1; #1;
      checkOutput("trap_rdy1_back", {31'd0, bus.Rdy1}, 32'd1);
      bus.Req1 = 1'b0;
      runVector(vecs[5]);
    end

    // Asynchronous reset in EXEC, then first contested grant goes to RR_INIT.
    issue(1'b0, 32'h11111111, 32'h22222222, 4'b0001, ok);
    if (ok) begin
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_alu", bus.AluA | bus.AluB, 32'd0);
      checkOutput("mid_rst_rsp", bus.RspRes, 32'd0);
      checkOutput("mid_rst_misc", {24'd0, bus.AluCtr, bus.RspVld0, bus.RspVld1, bus.Trap,
                                   bus.TrapId}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_grant", {30'd0, bus.Rdy1, bus.Rdy0}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester front end that time-shares one 32-bit ALU instance (ALU_32) in the SPU datapath. It accepts operation requests over valid/ready handshakes, arbitrates round-robin, drives registered operands and the 4-bit ALU control code into the ALU, and captures the result. It returns Res/Zero/Overfl to the granted requester through a held response handshake. It is the only driver of the shared ALU's inputs.

## Interface

Parameters:
- WIDTH, 32, operand/result width; must equal the ALU width; only 32 is supported.
- CTRW, 4, ALU control code width.
- RR_INIT, 0, requester that wins the first contested arbitration after reset (0 or 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- Req0, Req1  input  1  request valid per requester.
- Rdy0, Rdy1  output  1  request ready (combinational); a request is accepted when ReqN && RdyN at a clock edge.
- A0, B0, A1, B1  input  WIDTH  operands per requester.
- Ctr0, Ctr1  input  CTRW  ALU control code per requester, passed through unmodified.
- RspVld0, RspVld1  output  1  response valid to the requester that owns the transaction.
- Ack0, Ack1  input  1  response accept.
- RspRes  output  WIDTH  captured ALU result (shared bus).
- RspZero, RspOvf  output  1  captured ALU Zero and Overfl.
- AluA, AluB  output  WIDTH  to ALU operand inputs.
- AluCtr  output  CTRW  to ALU control input.
- AluRes  input  WIDTH  from ALU result.
- AluZero, AluOvf  input  1  from ALU flags.
- TrapClr  input  1  clears the overflow trap (see Configuration).
- Trap  output  1  sticky overflow trap.
- TrapId  output  1  requester that caused the trap.

## Operation

- States: IDLE, EXEC, RESP. Reset -> IDLE.
- IDLE: the grant is computed from Req0/Req1 and pointer Last (last served requester).
  - Only one request asserted: that requester is granted.
  - Both asserted: the requester != Last is granted.
  - Granted RdyN = 1, the other Rdy = 0. Rdy0 = Rdy1 = 0 in EXEC and RESP.
- On accept: latch A, B and Ctr of the granted requester into the operand registers; Owner <= N; Last <= N; go to EXEC.
- EXEC (exactly one cycle): AluA/AluB/AluCtr come from the operand registers (always register-driven, never combinational from the requesters). At the end of EXEC, capture AluRes/AluZero/AluOvf into the Rsp registers; go to RESP.
- RESP: RspVld[Owner] = 1, other RspVld = 0. The Rsp* outputs are held stable until AckOwner. On AckOwner go to IDLE. Ack of the non-owner is ignored.
- No new request is accepted in the same cycle as an Ack; IDLE is always visited.
- Req dropped before accept: no effect. Operand changes after accept do not affect the transaction.
- Ctr codes the ALU does not decode are still issued. The result is whatever the ALU produces (add path).

## Timing

- Accept at edge N. ALU inputs valid during cycle N+1. Result captured at edge N+2. RspVld is high from cycle N+2.
- Minimum issue interval: 3 cycles (Ack in the first response cycle).
- Reset values: state IDLE; Last = ~RR_INIT; Owner = 0; operand registers, AluA/AluB/AluCtr, RspRes, RspZero, RspOvf, RspVld0/1, Trap and TrapId all 0. Rdy follows Req in IDLE.
- rst mid-transaction: aborts immediately (asynchronous). The response is lost and all outputs return to reset values.

## Configuration

- ALU_ARB_OVTRAP_EN defined:
  - At the EXEC capture edge, AluOvf = 1 sets Trap = 1 and TrapId = Owner (sticky). The response is still delivered normally.
  - While Trap = 1, the requester TrapId is masked from arbitration (its Rdy is 0). The other requester is still served.
  - TrapClr = 1 clears Trap and TrapId at the next edge. If a new overflow capture occurs on that same edge, the set wins.
- Not defined: Trap = 0 and TrapId = 0 constantly, TrapClr is ignored, no masking. The ports remain present in both builds.

## Test plan

- Single op: Req0 with A0=0x7FFFFFFF, B0=1, Ctr0=4'b0001 (addu) -> Rdy0 high in IDLE; AluA/AluB driven the next cycle; RspVld0 = 1 two cycles after accept with RspRes=0x80000000, RspOvf=0, RspZero=0; held until Ack0.
- Round-robin: Req0 and Req1 held high from reset with RR_INIT=0 -> grant order 0,1,0,1. Requester 1 performs sub 5-5 and returns RspRes=0, RspZero=1.
- Slt signed/unsigned: A=0xFFFFFFFF, B=1; Ctr=4'b1010 -> RspRes=1; Ctr=4'b1011 -> RspRes=0.
- Backpressure: Ack withheld 10 cycles -> RspVld and Rsp* stable for all 10 cycles, Rdy0=Rdy1=0 throughout, Ack of the non-owner ignored.
- Overflow trap (macro on): Req1 add 0x7FFFFFFF+1 (Ctr=0000) -> RspOvf=1, Trap=1, TrapId=1; Rdy1 stays 0 while Req1 is held; requester 0 is still served; TrapClr pulse -> Trap=0 and requester 1 can be granted again. With the macro off, Trap stays 0.
- Reset mid-EXEC: assert rst during EXEC -> all outputs 0 immediately; after release, the first contested grant goes to RR_INIT.
